// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: bit-clock generator, 2-FF input sync, 3rd-order CIC decimator.
// Define PDM_RX_STEREO_EN to add a right-channel chain fed by fall-strobe bits.
module pdm_mic_rx #(
    parameter int CLK_DIV    = 8,
    parameter int DECIM_LOG2 = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        pdm_clk,
    input  logic        pdm_data,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic [15:0] pcm_data_l,
    output logic [15:0] pcm_data_r,
    output logic        pcm_overrun
);
    localparam int W  = 3 * DECIM_LOG2 + 2;
    localparam int SH = 3 * DECIM_LOG2 - 15;
    localparam int CW = $clog2(CLK_DIV);
`ifdef PDM_RX_STEREO_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif
    localparam logic signed [W-1:0] PMAX = W'(32767);
    localparam logic signed [W-1:0] PMIN = ~PMAX;

    logic [CW-1:0]         div_cnt;
    logic                  div_tc;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  dec_stb;
    logic                  sync1;
    logic                  sync2;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic [2:0]            comb_v;
    logic [1:0]            warm_cnt;
    logic [NCH*16-1:0]     pcm_new;
    logic                  load;
    logic                  xfer;

    assign div_tc   = (div_cnt == CW'(CLK_DIV - 1));
    assign rise_stb = enable && div_tc && !pdm_clk;
    assign fall_stb = enable && div_tc && pdm_clk;
    assign dec_stb  = rise_stb && (dec_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            sync1 <= pdm_data;
            sync2 <= sync1;
            if (!enable) begin
                div_cnt <= '0;
                pdm_clk <= 1'b0;
            end else if (div_tc) begin
                div_cnt <= '0;
                pdm_clk <= ~pdm_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // comb_v[k] marks comb stage k+1 holding a fresh result
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            dec_cnt  <= '0;
            comb_v   <= '0;
            warm_cnt <= '0;
        end else begin
            if (rise_stb)
                dec_cnt <= dec_cnt + 1'b1;
            comb_v <= {comb_v[1:0], dec_stb};
            if (comb_v[2] && warm_cnt != 2'd3)
                warm_cnt <= warm_cnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic                 stb;
        logic signed [W-1:0]  x;
        logic signed [W-1:0]  integ1, integ2, integ3;
        logic signed [W-1:0]  y1, y2, y3;
        logic signed [W-1:0]  d1, d2, d3;
        logic signed [W-1:0]  scaled;
        logic [15:0]          sat;

        assign stb = (ch == 0) ? rise_stb : fall_stb;
        // bit 1 -> +1, bit 0 -> -1
        assign x   = {{(W-1){~sync2}}, 1'b1};

        always_ff @(posedge clk) begin
            if (reset || !enable) begin
                integ1 <= '0;
                integ2 <= '0;
                integ3 <= '0;
                y1     <= '0;
                y2     <= '0;
                y3     <= '0;
                d1     <= '0;
                d2     <= '0;
                d3     <= '0;
            end else begin
                if (stb) begin
                    integ1 <= integ1 + x;
                    integ2 <= integ2 + integ1;
                    integ3 <= integ3 + integ2;
                end
                if (dec_stb) begin
                    y1 <= integ3 - d1;
                    d1 <= integ3;
                end
                if (comb_v[0]) begin
                    y2 <= y1 - d2;
                    d2 <= y1;
                end
                if (comb_v[1]) begin
                    y3 <= y2 - d3;
                    d3 <= y2;
                end
            end
        end

        assign scaled = y3 >>> SH;

        always_comb begin
            sat = scaled[15:0];
            if (scaled > PMAX)
                sat = 16'h7fff;
            else if (scaled < PMIN)
                sat = 16'h8000;
        end

        assign pcm_new[ch*16 +: 16] = sat;
    end

    assign load = enable && comb_v[2] && (warm_cnt == 2'd3);
    assign xfer = pcm_valid && pcm_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_valid   <= 1'b0;
            pcm_data_l  <= '0;
            pcm_overrun <= 1'b0;
        end else begin
            pcm_overrun <= 1'b0;
            if (load) begin
                pcm_data_l  <= pcm_new[15:0];
                pcm_valid   <= 1'b1;
                pcm_overrun <= pcm_valid && !pcm_ready;
            end else if (xfer) begin
                pcm_valid <= 1'b0;
            end
        end
    end

`ifdef PDM_RX_STEREO_EN
    always_ff @(posedge clk) begin
        if (reset)
            pcm_data_r <= '0;
        else if (load)
            pcm_data_r <= pcm_new[NCH*16-1 -: 16];
    end
`else
    assign pcm_data_r = pcm_data_l;
`endif

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed bench for pdm_mic_rx (mono build, default parameters).
// Checks reset, full-scale, alternating, backpressure, enable drop and reset.
module tb_pdm_mic_rx;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pdm_clk;
    logic        pdm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic [15:0] pcm_data_l;
    logic [15:0] pcm_data_r;
    logic        pcm_overrun;

    logic const_bit = 1'b0;
    logic alt_mode  = 1'b0;
    logic alt_bit   = 1'b0;

    int checks = 0;
    int errors = 0;

    pdm_mic_rx dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pdm_clk    (pdm_clk),
        .pdm_data   (pdm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .pcm_data_l (pcm_data_l),
        .pcm_data_r (pcm_data_r),
        .pcm_overrun(pcm_overrun)
    );

    always #5 clk = ~clk;

    // the microphone changes its bit once per bit-clock period
    always @(posedge pdm_clk) alt_bit = ~alt_bit;
    assign pdm_data = alt_mode ? alt_bit : const_bit;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_valid(input int max, output int n, output int ok);
        n  = 0;
        ok = 0;
        while (n < max && ok == 0) begin
            @(negedge clk);
            n++;
            if (pcm_valid) ok = 1;
        end
    endtask

    task automatic skip(input int k);
        int n, ok;
        for (int i = 0; i < k; i++) wait_valid(2000, n, ok);
    endtask

    initial begin
        int n, ok, ovr, drops, seen, vcnt, pclk_hi;

        reset     = 1'b1;
        enable    = 1'b0;
        pcm_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pdm_clk", int'(pdm_clk), 0);
        chk("rst_valid", int'(pcm_valid), 0);
        chk("rst_data_l", int'(pcm_data_l), 0);
        chk("rst_data_r", int'(pcm_data_r), 0);
        chk("rst_overrun", int'(pcm_overrun), 0);

        // all ones: first sample after three discarded results
        const_bit = 1'b1;
        reset     = 1'b0;
        enable    = 1'b1;
        wait_valid(6000, n, ok);
        chk("ones_first_seen", ok, 1);
        chk_rng("ones_first_latency", n, 4080, 4100);
        chk("ones_data_l", int'(pcm_data_l), 32767);
        chk("ones_data_r", int'(pcm_data_r), 32767);
        wait_valid(2000, n, ok);
        chk("ones_period", n, 1024);
        chk("ones_data_l2", int'(pcm_data_l), 32767);

        // all zeros
        const_bit = 1'b0;
        skip(5);
        for (int i = 0; i < 2; i++) begin
            wait_valid(2000, n, ok);
            chk("zeros_seen", ok, 1);
            chk("zeros_data_l", int'(pcm_data_l), 32768);
            chk("zeros_data_r", int'(pcm_data_r), 32768);
        end

        // alternating bits
        alt_mode = 1'b1;
        skip(5);
        for (int i = 0; i < 2; i++) begin
            wait_valid(2000, n, ok);
            chk("alt_seen", ok, 1);
            chk("alt_data_l", int'(pcm_data_l), 0);
        end

        // backpressure: hold ready low across three new samples
        alt_mode  = 1'b0;
        const_bit = 1'b1;
        skip(5);
        repeat (1000) @(negedge clk);
        pcm_ready = 1'b0;
        ovr   = 0;
        drops = 0;
        seen  = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (pcm_overrun) ovr++;
            if (pcm_valid) seen = 1;
            else if (seen == 1) drops++;
        end
        chk("bp_overruns", ovr, 2);
        chk("bp_valid_drops", drops, 0);
        chk("bp_valid_held", int'(pcm_valid), 1);
        chk("bp_data_l", int'(pcm_data_l), 32767);
        pcm_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_after_xfer", int'(pcm_valid), 0);

        // enable drop while the bit clock is high
        n = 0;
        while (pdm_clk == 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("en_pdm_clk_high", int'(pdm_clk), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("en_pdm_clk_low", int'(pdm_clk), 0);
        pclk_hi = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (pdm_clk) pclk_hi++;
        end
        chk("en_pdm_clk_idle", pclk_hi, 0);
        enable = 1'b1;
        wait_valid(6000, n, ok);
        chk("en_return_seen", ok, 1);
        chk_rng("en_return_latency", n, 4080, 4100);
        chk("en_data_l", int'(pcm_data_l), 32767);

        // reset while a sample is held
        pcm_ready = 1'b0;
        wait_valid(2000, n, ok);
        chk("rst2_valid_before", ok, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_pdm_clk", int'(pdm_clk), 0);
        chk("rst2_valid", int'(pcm_valid), 0);
        chk("rst2_data_l", int'(pcm_data_l), 0);
        chk("rst2_data_r", int'(pcm_data_r), 0);
        chk("rst2_overrun", int'(pcm_overrun), 0);
        reset     = 1'b0;
        pcm_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (pcm_valid) vcnt++;
        end
        chk("rst2_no_valid_warmup", vcnt, 0);
        wait_valid(300, n, ok);
        chk("rst2_valid_returns", ok, 1);
        chk("rst2_data_l_after", int'(pcm_data_l), 32767);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_mic_rx.md
# pdm_mic_rx

PDM microphone receiver: the input-side counterpart of the 1-bit delta-sigma audio output path. It generates the microphone bit clock, samples the 1-bit PDM stream and decimates it with a 3rd-order CIC filter into signed 16-bit PCM. Samples go out over a valid/ready handshake to user logic in the audio clock domain.

## Interface
Parameters:
- CLK_DIV, 8: clk cycles per half period of pdm_clk; must be ≥ 4. The PDM rate is clk / (2·CLK_DIV).
- DECIM_LOG2, 6: log2 of the decimation ratio; range 5..8. The default gives R = 64.

Ports:
- clk  in  1  block clock; one clock; all logic is synchronous to its rising edge
- reset  in  1  reset is synchronous and active-high
- enable  in  1  run/stop; when low, the capture path is held idle
- pdm_clk  out  1  bit clock to the microphone, registered
- pdm_data  in  1  PDM data from the microphone; asynchronous to clk
- pcm_valid  out  1  PCM sample available
- pcm_ready  in  1  consumer accepts the sample
- pcm_data_l  out  16  left sample, signed two's complement
- pcm_data_r  out  16  right sample when PDM_RX_STEREO_EN is defined, otherwise equal to pcm_data_l
- pcm_overrun  out  1  one-cycle pulse: an unaccepted sample was overwritten

## Operation
- **Reset values:** pdm_clk=0, pcm_valid=0, pcm_data_l/r=0, pcm_overrun=0. Integrators, combs, counters and the warm-up count are all cleared.
- **Bit clock:** a divider counts 0..CLK_DIV-1. At the terminal count, pdm_clk toggles.
- **Input synchronizer:** pdm_data passes through a 2-FF synchronizer before any use.
- **Rise strobe:** asserted in the cycle where pdm_clk goes 0→1. On this strobe the synchronizer output is taken as the left bit.
- **Fall strobe:** asserted on the 1→0 cycle. Used only in stereo builds.
- **Bit mapping:** bit 1 → +1, bit 0 → −1.
- **CIC width:** W = 3·DECIM_LOG2+2 bits, signed, modular (wrap-around permitted and required).
- **Integrators:** three cascaded integrators update once per rise strobe.
- **Decimation counter:** counts rise strobes 0..R−1. At R−1 it raises a decimation strobe that captures integrator 3.
- **Combs:** three comb stages (y = x − x_prev) run one stage per clk cycle after the decimation strobe.
- **Scaling:** comb result ≫ (3·DECIM_LOG2−15), arithmetic shift, then saturation to [−32768, 32767]. Full-scale +R³ maps to 32767 and −R³ to −32768.
- **Warm-up:** the first 3 decimated results after reset or an enable rise are discarded and do not raise pcm_valid.
- **Handshake:**
  - A transfer occurs on a cycle with pcm_valid && pcm_ready.
  - pcm_valid falls the cycle after a transfer unless a new sample loads in the same cycle.
  - Data is stable while pcm_valid=1 && pcm_ready=0.
- **Overrun:** a new sample arrives while pcm_valid=1 and no transfer happens that cycle. The new sample overwrites the held one, pcm_valid stays 1 and pcm_overrun pulses for 1 cycle.
- **Simultaneous transfer and new sample:** the held sample transfers, the new sample loads, pcm_valid stays 1 and there is no overrun.
- **enable low:**
  - The divider is held at 0 and pdm_clk is forced to 0 at the next edge.
  - Integrators, combs, the decimation counter and the warm-up count are cleared.
  - A held output sample remains valid until it is accepted.
- **reset mid-operation:** all state returns to reset values on the next edge, including any held sample.

## Timing
- PDM sample period: 2·CLK_DIV clk cycles (16 at the default).
- Output period: 2·CLK_DIV·R clk cycles (1024 at the default).
- Latency: pcm_valid rises 4 clk cycles after the decimation strobe (3 comb stages + scale/saturate register).
- Bit alignment: the bit sampled on a rise strobe reflects the pad level 2–3 cycles earlier. This lies inside the low phase because CLK_DIV ≥ 4.
- First valid sample: at 4 output periods + 4 cycles after enable rises, at most.

## Configuration
- **PDM_RX_STEREO_EN defined:**
  - The bit sampled on the fall strobe feeds a second, identical CIC chain for the right channel.
  - Both chains share the decimation counter and strobe.
  - pcm_data_l and pcm_data_r load together under one pcm_valid.
- **PDM_RX_STEREO_EN undefined:**
  - There is only one chain; fall-strobe data is ignored.
  - pcm_data_r is driven with the pcm_data_l value.

## Test plan
- **All ones:** pdm_data=1 constant, default parameters, pcm_ready=1 → after warm-up every sample is pcm_data_l=32767 and pcm_valid pulses every 1024 cycles.
- **All zeros:** pdm_data=0 constant → every post-warm-up sample is −32768 (0x8000).
- **Alternating bits:** pdm_data alternates 1,0 per rise strobe → steady-state samples are exactly 0. In the stereo build, set right=1 and left=0 constant → left −32768, right 32767.
- **Backpressure:** pcm_ready=0 for 2500 cycles with a constant stream → pcm_valid stays high, 2 overrun pulses, data equals the newest sample. Raise ready → 1 transfer, then pcm_valid drops.
- **Enable drop:** drop enable for 100 cycles mid-frame → pdm_clk=0 the next cycle. After re-enable, exactly 3 decimated results are suppressed before pcm_valid returns.
- **Reset:** assert reset while pcm_valid=1 → next cycle all outputs are 0, and no transfer occurs afterwards until warm-up completes.
